// File: rtl/addsub_pkg.sv
// Shared types and constants for the chunk-serial adder/subtractor.
package addsub_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } addsub_state_t;

    localparam logic ADDSUB_ADD = 1'b1;
    localparam logic ADDSUB_SUB = 1'b0;

    // Chunk counter width; a single-chunk build still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/addsub_serial_chunk.sv
// CHUNK-bit combinational ripple slice used by addsub_serial for one step.
module addsub_chunk #(
    parameter int CHUNK = 1
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] sum,
    output logic             co,
    output logic             msb_ci
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = ci;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            sum[i]   = x[i] ^ y[i] ^ c[i];
            c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign co     = c[CHUNK];
    assign msb_ci = c[CHUNK-1];

endmodule

// File: rtl/addsub_serial.sv
// Chunk-serial add/subtract with start/done handshake, carry-out and signed overflow.
// Optional ADDSUB_SERIAL_SAT_EN clamps the result to signed max/min on overflow.
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             a_ns,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = cnt_width(NCHUNK);

    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("addsub_serial: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    addsub_state_t    state, state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic [WIDTH-1:0] b_load;
    logic [WIDTH-1:0] s_shift;
    logic             carry;
    logic             a_msb, b_msb;
    logic             accept, last;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_co, chunk_msb_ci;
    logic             ovf_next;

    addsub_chunk #(
        .CHUNK(CHUNK)
    ) u_chunk (
        .x      (a_sr[CHUNK-1:0]),
        .y      (b_sr[CHUNK-1:0]),
        .ci     (carry),
        .sum    (chunk_sum),
        .co     (chunk_co),
        .msb_ci (chunk_msb_ci)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last       = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == CW'(NCHUNK - 1)) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign b_load = (a_ns == ADDSUB_SUB) ? ~b : b;

    // Result fills from the MSB side, so the final chunk lands in the top bits.
    if (NCHUNK == 1) begin : g_single
        assign s_shift = chunk_sum;
    end else begin : g_multi
        assign s_shift = {chunk_sum, s[WIDTH-1:CHUNK]};
    end

    assign ovf_next = (a_msb == b_msb) && (chunk_sum[CHUNK-1] != a_msb);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr  <= '0;
            b_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= last;
            if (accept) begin
                a_sr  <= a;
                b_sr  <= b_load;
                carry <= ~a_ns;
                cnt   <= '0;
                a_msb <= a[WIDTH-1];
                b_msb <= b_load[WIDTH-1];
            end else if (busy) begin
                a_sr  <= a_sr >> CHUNK;
                b_sr  <= b_sr >> CHUNK;
                carry <= chunk_co;
                cnt   <= cnt + CW'(1);
                s     <= s_shift;
                if (last) begin
                    cout <= chunk_co;
                    ovf  <= ovf_next;
`ifdef ADDSUB_SERIAL_SAT_EN
                    if (ovf_next) begin
                        s <= {a_msb, {(WIDTH-1){~a_msb}}};
                    end
`endif
                end
            end
        end
    end

    // Sign-bit formula must agree with carry-in/carry-out of the top bit.
    property p_ovf_consistent;
        @(posedge clk) disable iff (!rst_n)
            last |-> (ovf_next == (chunk_co ^ chunk_msb_ci));
    endproperty
    a_ovf_consistent: assert property (p_ovf_consistent);

endmodule

// File: tb/tb_addsub_serial.sv
// Directed self-checking bench for addsub_serial (8/1 and 16/4 configurations).
module tb_addsub_serial;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       start8 = 1'b0, mode8 = 1'b1;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] s8;

    logic        start16 = 1'b0, mode16 = 1'b1;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] s16;

    int total = 0;
    int bad   = 0;

`ifdef ADDSUB_SERIAL_SAT_EN
    localparam logic [7:0]  EXP_ADD_OVF  = 8'h7F;
    localparam logic [7:0]  EXP_SUB_OVF  = 8'h80;
    localparam logic [15:0] EXP_ADD16_OV = 16'h8000;
`else
    localparam logic [7:0]  EXP_ADD_OVF  = 8'h80;
    localparam logic [7:0]  EXP_SUB_OVF  = 8'h7F;
    localparam logic [15:0] EXP_ADD16_OV = 16'h0000;
`endif

    always #5 clk = ~clk;

    addsub_serial #(.WIDTH(8), .CHUNK(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a_ns(mode8),
        .a(a8), .b(b8), .busy(busy8), .done(done8),
        .s(s8), .cout(cout8), .ovf(ovf8)
    );

    addsub_serial #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a_ns(mode16),
        .a(a16), .b(b16), .busy(busy16), .done(done16),
        .s(s16), .cout(cout16), .ovf(ovf16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present a request now; it is taken at the next rising edge.
    task automatic go8(input logic m, input logic [7:0] x, input logic [7:0] y);
        start8 = 1'b1; mode8 = m; a8 = x; b8 = y;
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); mode8 = 1'($urandom);
    endtask

    task automatic wait_done8(output int n, output int nb);
        n = 0; nb = 0;
        while (!done8 && n < 40) begin
            if (busy8) nb++;
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic op8(input string tag, input logic m, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] es, input logic ec, input logic ev);
        int n, nb;
        go8(m, x, y);
        wait_done8(n, nb);
        check({tag, "_lat"}, n, 8);
        check({tag, "_busy"}, nb, 8);
        check({tag, "_s"}, s8, es);
        check({tag, "_cout"}, cout8, ec);
        check({tag, "_ovf"}, ovf8, ev);
    endtask

    task automatic op16(input string tag, input logic m, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] es, input logic ec, input logic ev);
        int n;
        start16 = 1'b1; mode16 = m; a16 = x; b16 = y;
        @(posedge clk); #1;
        start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
        n = 0;
        while (!done16 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, n, 4);
        check({tag, "_s"}, s16, es);
        check({tag, "_cout"}, cout16, ec);
        check({tag, "_ovf"}, ovf16, ev);
    endtask

    initial begin
        int n, nb;
        logic seen;

        repeat (2) @(posedge clk);
        #1;
        check("rst_s8", s8, 8'h00);
        check("rst_busy8", busy8, 1'b0);
        check("rst_done8", done8, 1'b0);
        check("rst_cout8", cout8, 1'b0);
        check("rst_ovf8", ovf8, 1'b0);
        check("rst_s16", s16, 16'h0000);
        check("rst_busy16", busy16, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        op8("add", 1'b1, 8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("done_pulse", done8, 1'b0);
        check("hold_s", s8, 8'h7F);

        op8("add_ovf", 1'b1, 8'h7F, 8'h01, EXP_ADD_OVF, 1'b0, 1'b1);
        @(posedge clk); #1;
        op8("sub", 1'b0, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0);
        @(posedge clk); #1;
        op8("sub_ovf", 1'b0, 8'h80, 8'h01, EXP_SUB_OVF, 1'b1, 1'b1);
        @(posedge clk); #1;

        // Second request raised in the done cycle of the first.
        op8("add_wrap", 1'b1, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        op8("b2b", 1'b1, 8'h02, 8'h03, 8'h05, 1'b0, 1'b0);
        @(posedge clk); #1;

        go8(1'b1, 8'h35, 8'h4A);
        repeat (3) begin @(posedge clk); #1; end
        start8 = 1'b1; mode8 = 1'b0; a8 = 8'h11; b8 = 8'h22;
        @(posedge clk); #1;
        start8 = 1'b0;
        wait_done8(n, nb);
        check("ign_lat", n + 4, 8);
        check("ign_s", s8, 8'h7F);
        check("ign_cout", cout8, 1'b0);
        @(posedge clk); #1;
        check("ign_idle", busy8, 1'b0);

        go8(1'b1, 8'h35, 8'h4A);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("abort_s", s8, 8'h00);
        check("abort_busy", busy8, 1'b0);
        check("abort_done", done8, 1'b0);
        check("abort_cout", cout8, 1'b0);
        check("abort_ovf", ovf8, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done8) seen = 1'b1;
        end
        check("abort_nodone", seen, 1'b0);
        op8("after_rst", 1'b1, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0);
        @(posedge clk); #1;

        op16("sub16", 1'b0, 16'h1234, 16'h0235, 16'h0FFF, 1'b1, 1'b0);
        @(posedge clk); #1;
        op16("add16_ovf", 1'b1, 16'h8000, 16'h8000, EXP_ADD16_OV, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
